rename_reg_file: RTL and testbench

- Parametrised architectural register file with rename status (busy bit plus ROB tag per register) for the Tomasulo core.
- Sits between the issue/cmd stage and the ROB.
- Adds to the previous generation:
  - explicit busy bits instead of a reserved invalid tag;
  - tag-checked commit bypass;
  - NUM_CKPT branch checkpoints of the rename table, giving selective mispredict recovery in addition to full flush.

---
 rtl/rename_reg_file.sv | 164 ++++++++++++++++
 tb/tb_rename_reg_file.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename status (busy + ROB tag)
// and a ring of branch checkpoints for selective mispredict recovery.
module rename_reg_file #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int ROB_ID_W = 4,
    parameter int NUM_CKPT = 4,
    parameter int CKPT_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_en,
    input  logic [REG_W-1:0]    issue_rd,
    input  logic [ROB_ID_W-1:0] issue_rob_id,
    input  logic                issue_ckpt,
    input  logic [REG_W-1:0]    rs1,
    input  logic [REG_W-1:0]    rs2,
    output logic [XLEN-1:0]     v1,
    output logic [XLEN-1:0]     v2,
    output logic                busy1,
    output logic                busy2,
    output logic [ROB_ID_W-1:0] q1,
    output logic [ROB_ID_W-1:0] q2,
    output logic [CKPT_W-1:0]   ckpt_id,
    output logic                ckpt_full,
    output logic                ckpt_empty,
    input  logic                commit_en,
    input  logic [REG_W-1:0]    commit_rd,
    input  logic [ROB_ID_W-1:0] commit_rob_id,
    input  logic [XLEN-1:0]     commit_value,
    input  logic                release_en,
    input  logic                restore_en,
    input  logic [CKPT_W-1:0]   restore_id,
    input  logic                flush
);

    logic [XLEN-1:0]     val_q  [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ROB_ID_W-1:0] tag_q  [NUM_REGS];
    logic [ROB_ID_W-1:0] tag_d  [NUM_REGS];

    logic [NUM_REGS-1:0] cbusy_q [NUM_CKPT];
    logic [ROB_ID_W-1:0] ctag_q  [NUM_CKPT][NUM_REGS];

    logic [CKPT_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CKPT_W:0]   count_q, count_d;

    logic commit_act, issue_act, snap, rel;
    logic [NUM_CKPT-1:0] ck_wr, ck_clr;

    assign commit_act = commit_en && (commit_rd != '0);
    assign issue_act  = issue_en && (issue_rd != '0);
    assign ckpt_full  = (count_q == (CKPT_W+1)'(NUM_CKPT));
    assign ckpt_empty = (count_q == '0);
    assign ckpt_id    = tail_q;
    assign snap = !flush && !restore_en && issue_ckpt && !ckpt_full;
    assign rel  = !flush && !restore_en && release_en && !ckpt_empty;

    // Read ports: the commit bypass only fires when the committing tag is the live producer.
    logic [1:0][REG_W-1:0]    rs_idx;
    logic [1:0][XLEN-1:0]     rd_v;
    logic [1:0]               rd_busy;
    logic [1:0][ROB_ID_W-1:0] rd_q;
    assign rs_idx[0] = rs1;
    assign rs_idx[1] = rs2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_read
        logic byp;
        assign byp = commit_act && (commit_rd == rs_idx[gi]) && busy_q[rs_idx[gi]]
                     && (tag_q[rs_idx[gi]] == commit_rob_id);
        assign rd_v[gi]    = (rs_idx[gi] == '0) ? '0 : (byp ? commit_value : val_q[rs_idx[gi]]);
        assign rd_busy[gi] = (rs_idx[gi] != '0) && busy_q[rs_idx[gi]] && !byp;
        assign rd_q[gi]    = tag_q[rs_idx[gi]];
    end

    assign v1    = rd_v[0];
    assign v2    = rd_v[1];
    assign busy1 = rd_busy[0];
    assign busy2 = rd_busy[1];
    assign q1    = rd_q[0];
    assign q2    = rd_q[1];

    // A slot is live when its distance from head is below count.
    for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_ckpt
        logic [CKPT_W-1:0] age;
        assign age        = CKPT_W'(gi) - head_q;
        assign ck_wr[gi]  = snap && (tail_q == CKPT_W'(gi));
        assign ck_clr[gi] = ({1'b0, age} < count_q) && commit_act
                            && (ctag_q[gi][commit_rd] == commit_rob_id);
    end

    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (restore_en) begin
                busy_d = cbusy_q[restore_id];
                tag_d  = ctag_q[restore_id];
            end
            if (commit_act && (tag_d[commit_rd] == commit_rob_id))
                busy_d[commit_rd] = 1'b0;
            if (!restore_en && issue_act) begin
                busy_d[issue_rd] = 1'b1;
                tag_d[issue_rd]  = issue_rob_id;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (restore_en) begin
            tail_d  = restore_id;
            count_d = {1'b0, restore_id - head_q};
        end else begin
            tail_d  = tail_q + CKPT_W'(snap);
            head_d  = head_q + CKPT_W'(rel);
            count_d = count_q + (CKPT_W+1)'(snap) - (CKPT_W+1)'(rel);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            tag_q   <= tag_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (commit_act)
                val_q[commit_rd] <= commit_value;
        end
    end

    // Checkpoint storage needs no reset: a slot is only read once it has been written.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_CKPT; s++) begin
            if (ck_wr[s]) begin
                cbusy_q[s] <= busy_d;
                ctag_q[s]  <= tag_d;
            end else if (ck_clr[s]) begin
                cbusy_q[s][commit_rd] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Randomised + directed bench for rename_reg_file against a queue-based checkpoint model.
module tb_rename_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_en, issue_ckpt, commit_en, release_en, restore_en, flush;
    logic [4:0]  issue_rd, rs1, rs2, commit_rd;
    logic [3:0]  issue_rob_id, commit_rob_id;
    logic [31:0] commit_value;
    logic [1:0]  restore_id;
    logic [31:0] v1, v2;
    logic        busy1, busy2, ckpt_full, ckpt_empty;
    logic [3:0]  q1, q2;
    logic [1:0]  ckpt_id;

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    rename_reg_file dut (
        .clk(clk), .rst(rst),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id), .issue_ckpt(issue_ckpt),
        .rs1(rs1), .rs2(rs2), .v1(v1), .v2(v2), .busy1(busy1), .busy2(busy2), .q1(q1), .q2(q2),
        .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_empty(ckpt_empty),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
        .commit_value(commit_value), .release_en(release_en), .restore_en(restore_en),
        .restore_id(restore_id), .flush(flush)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays for the table, an oldest-first queue of snapshots.
    typedef struct packed {
        logic [31:0]  b;
        logic [127:0] t;
    } ck_t;

    logic [31:0] m_v    [32];
    logic        m_busy [32];
    logic [3:0]  m_q    [32];
    ck_t         m_ck   [$];
    int          m_head;

    function automatic ck_t snap_table();
        ck_t e;
        for (int r = 0; r < 32; r++) begin
            e.b[r]        = m_busy[r];
            e.t[r*4 +: 4] = m_q[r];
        end
        return e;
    endfunction

    task automatic clear_in_ckpts(input logic [4:0] rd, input logic [3:0] tag);
        ck_t e;
        for (int k = 0; k < m_ck.size(); k++) begin
            e = m_ck[k];
            if (e.b[rd] && e.t[rd*4 +: 4] == tag) e.b[rd] = 1'b0;
            m_ck[k] = e;
        end
    endtask

    always @(posedge clk) begin : model_update
        int  pre, idx;
        ck_t e;
        bit  c_act, i_act;
        c_act = commit_en && commit_rd != 0;
        i_act = issue_en && issue_rd != 0;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_v[r] = 0; m_busy[r] = 0; m_q[r] = 0;
            end
            m_ck.delete();
            m_head = 0;
        end else begin
            if (c_act) m_v[commit_rd] = commit_value;
            if (flush) begin
                for (int r = 0; r < 32; r++) m_busy[r] = 0;
                m_ck.delete();
                m_head = 0;
            end else if (restore_en) begin
                idx = (int'(restore_id) - m_head + 4) % 4;
                e = m_ck[idx];
                for (int r = 0; r < 32; r++) begin
                    m_busy[r] = e.b[r];
                    m_q[r]    = e.t[r*4 +: 4];
                end
                while (m_ck.size() > idx) m_ck.delete(m_ck.size() - 1);
                if (c_act && m_q[commit_rd] == commit_rob_id) m_busy[commit_rd] = 0;
                if (c_act) clear_in_ckpts(commit_rd, commit_rob_id);
            end else begin
                pre = m_ck.size();
                if (c_act && m_q[commit_rd] == commit_rob_id && !(i_act && issue_rd == commit_rd))
                    m_busy[commit_rd] = 0;
                if (i_act) begin
                    m_busy[issue_rd] = 1;
                    m_q[issue_rd]    = issue_rob_id;
                end
                if (c_act) clear_in_ckpts(commit_rd, commit_rob_id);
                if (issue_ckpt && pre < 4) m_ck.push_back(snap_table());
                if (release_en && pre > 0) begin
                    m_ck.delete(0);
                    m_head = (m_head + 1) % 4;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_read(input logic [4:0] rs, output logic [31:0] v,
                                     output logic b, output logic [3:0] q);
        q = m_q[rs];
        if (rs == 0) begin
            v = 0; b = 0;
        end else if (commit_en && commit_rd == rs && m_busy[rs] && m_q[rs] == commit_rob_id) begin
            v = commit_value; b = 0;
        end else begin
            v = m_v[rs]; b = m_busy[rs];
        end
    endfunction

    always @(negedge clk) begin : compare
        logic [31:0] ev;
        logic        eb;
        logic [3:0]  eq;
        if (checking) begin
            exp_read(rs1, ev, eb, eq);
            chk("v1", v1, ev);
            chk("busy1", {31'd0, busy1}, {31'd0, eb});
            if (eb) chk("q1", {28'd0, q1}, {28'd0, eq});
            exp_read(rs2, ev, eb, eq);
            chk("v2", v2, ev);
            chk("busy2", {31'd0, busy2}, {31'd0, eb});
            if (eb) chk("q2", {28'd0, q2}, {28'd0, eq});
            chk("ckpt_id", {30'd0, ckpt_id}, 32'((m_head + m_ck.size()) % 4));
            chk("ckpt_full", {31'd0, ckpt_full}, {31'd0, m_ck.size() == 4});
            chk("ckpt_empty", {31'd0, ckpt_empty}, {31'd0, m_ck.size() == 0});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rst = 0; issue_en = 0; issue_ckpt = 0; commit_en = 0; release_en = 0;
        restore_en = 0; flush = 0; issue_rd = 0; issue_rob_id = 0; commit_rd = 0;
        commit_rob_id = 0; commit_value = 0; restore_id = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] tag, input logic ck);
        issue_en = 1; issue_rd = rd; issue_rob_id = tag; issue_ckpt = ck;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] val);
        commit_en = 1; commit_rd = rd; commit_rob_id = tag; commit_value = val;
    endtask

    initial begin
        tick();
        rst = 1;
        tick();
        rst = 1;
        tick();
        checking = 1;

        // Reset state
        rs1 = 3; rs2 = 0; #2;
        chk("rst_v1", v1, 0); chk("rst_busy1", {31'd0, busy1}, 0); chk("rst_v2", v2, 0);
        chk("rst_empty", {31'd0, ckpt_empty}, 1); chk("rst_full", {31'd0, ckpt_full}, 0);
        chk("rst_ckpt_id", {30'd0, ckpt_id}, 0);
        $display("step reset: v1=%0h busy1=%0b empty=%0b", v1, busy1, ckpt_empty);

        // Commit bypass
        tick(); do_issue(5, 7, 0);
        tick(); do_commit(5, 7, 32'hAB); rs1 = 5; #2;
        chk("byp_v1", v1, 32'hAB); chk("byp_busy1", {31'd0, busy1}, 0);
        tick(); rs1 = 5; #2;
        chk("post_v1", v1, 32'hAB); chk("post_busy1", {31'd0, busy1}, 0);
        $display("step bypass: v1=%0h busy1=%0b", v1, busy1);

        // Stale commit and same-cycle issue/commit
        tick(); do_issue(5, 2, 0);
        tick(); do_issue(5, 9, 0);
        tick(); do_commit(5, 2, 32'h11);
        tick(); rs1 = 5; do_issue(6, 4, 0); do_commit(6, 4, 32'h66); #2;
        chk("stale_v1", v1, 32'h11); chk("stale_busy1", {31'd0, busy1}, 1); chk("stale_q1", {28'd0, q1}, 9);
        tick(); rs1 = 6; #2;
        chk("same_busy", {31'd0, busy1}, 1); chk("same_q", {28'd0, q1}, 4);
        $display("step stale: r5 busy r6 busy=%0b q=%0d", busy1, q1);

        // Checkpoint restore after commit
        tick(); do_issue(1, 1, 1);
        tick(); do_issue(2, 2, 0);
        tick(); do_commit(1, 1, 32'h1);
        tick(); restore_en = 1; restore_id = 0;
        tick(); rs1 = 1; rs2 = 2; #2;
        chk("rest_busy1", {31'd0, busy1}, 0); chk("rest_busy2", {31'd0, busy2}, 0);
        chk("rest_ckpt_id", {30'd0, ckpt_id}, 0); chk("rest_empty", {31'd0, ckpt_empty}, 1);
        $display("step restore: busy1=%0b busy2=%0b id=%0d", busy1, busy2, ckpt_id);

        // Fill, drop, release, snapshot+release
        for (int k = 0; k < 4; k++) begin
            tick(); issue_ckpt = 1;
        end
        tick(); #2;
        chk("fill_full", {31'd0, ckpt_full}, 1); chk("fill_id", {30'd0, ckpt_id}, 0);
        issue_ckpt = 1;
        tick(); #2;
        chk("drop_full", {31'd0, ckpt_full}, 1);
        release_en = 1;
        tick(); #2;
        chk("rel_full", {31'd0, ckpt_full}, 0); chk("rel_empty", {31'd0, ckpt_empty}, 0);
        issue_ckpt = 1; release_en = 1;
        tick(); #2;
        chk("sr_full", {31'd0, ckpt_full}, 0); chk("sr_id", {30'd0, ckpt_id}, 1);
        $display("step ring: full=%0b id=%0d", ckpt_full, ckpt_id);

        // Flush with commit
        do_issue(3, 5, 1);
        tick(); flush = 1; do_commit(4, 0, 32'h55);
        tick(); rs1 = 3; rs2 = 4; #2;
        chk("fl_busy1", {31'd0, busy1}, 0); chk("fl_v2", v2, 32'h55); chk("fl_empty", {31'd0, ckpt_empty}, 1);
        $display("step flush: busy1=%0b v2=%0h empty=%0b", busy1, v2, ckpt_empty);

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            tick();
            rs1 = 5'($urandom); rs2 = 5'($urandom);
            if ($urandom_range(0, 1) == 0) do_issue(5'($urandom), 4'($urandom), 1'b0);
            if ($urandom_range(0, 3) == 0 && (m_ck.size() < 4 || $urandom_range(0, 3) == 0))
                issue_ckpt = 1;
            if ($urandom_range(0, 9) < 6) begin
                commit_en = 1; commit_rd = 5'($urandom);
                commit_rob_id = ($urandom_range(0, 9) < 7) ? m_q[commit_rd] : 4'($urandom);
                commit_value = $urandom;
                if ($urandom_range(0, 3) == 0) rs1 = commit_rd;
            end
            if ($urandom_range(0, 6) == 0) release_en = 1;
            if (m_ck.size() > 0 && $urandom_range(0, 19) == 0) begin
                restore_en = 1;
                restore_id = 2'((m_head + int'($urandom_range(0, m_ck.size() - 1))) % 4);
            end
            if ($urandom_range(0, 49) == 0) flush = 1;
            if ($urandom_range(0, 299) == 0) rst = 1;
        end
        tick();
        @(negedge clk);
        checking = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
